// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: fetches one or two program-memory words per
// instruction, issues them to the decoder with a valid/ready handshake and
// owns the program counter, including redirects from the execute stage.
module fetch_sequencer #(
  parameter int unsigned         PC_WIDTH     = 14,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] pm_addr,
  input  logic [15:0]         pm_rdata,
  output logic [15:0]         dec_instruction,
  output logic                dec_part2,
  output logic                issue_valid,
  input  logic                issue_ready,
  input  logic                pc_load,
  input  logic [PC_WIDTH-1:0] pc_load_value,
  output logic [PC_WIDTH-1:0] pc
);

  typedef enum logic [2:0] {
    StFetch1,
    StLatch1,
    StFetch2,
    StLatch2,
    StIssue1,
    StIssue2
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;
  logic [15:0]         op2_q, op2_d;
  logic                ir_long;

  // CALL/JMP share w[3:2]=11 (w[1] selects between them); LDS/STS need w[3:0]=0.
  function automatic logic is_long(input logic [15:0] w);
    logic call_jmp, lds, sts;
    call_jmp = (w[15:9] == 7'b1001010) && (w[3:2] == 2'b11);
    lds      = (w[15:9] == 7'b1001000) && (w[3:0] == 4'b0000);
    sts      = (w[15:9] == 7'b1001001) && (w[3:0] == 4'b0000);
    return call_jmp || lds || sts;
  endfunction

  assign ir_long = is_long(ir_q);
  assign pm_addr = pc_q;
  assign pc      = pc_q;

  // Next-state, PC/instruction register updates and decoder outputs.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    ir_d            = ir_q;
    op2_d           = op2_q;
    issue_valid     = 1'b0;
    dec_part2       = 1'b0;
    dec_instruction = ir_q;

    case (state_q)
      StFetch1: begin
        state_d = StLatch1;
      end
      StLatch1: begin
        ir_d    = pm_rdata;
        pc_d    = pc_q + PC_WIDTH'(1);
        state_d = is_long(pm_rdata) ? StFetch2 : StIssue1;
      end
      StFetch2: begin
        state_d = StLatch2;
      end
      StLatch2: begin
        op2_d   = pm_rdata;
        pc_d    = pc_q + PC_WIDTH'(1);
        state_d = StIssue1;
      end
      StIssue1: begin
        issue_valid = 1'b1;
        if (issue_ready) begin
          // A long opcode's redirect target lives in word 2, so hold off until then.
          if (ir_long) begin
            state_d = StIssue2;
          end else begin
            if (pc_load) begin
              pc_d = pc_load_value;
            end
            state_d = StFetch1;
          end
        end
      end
      StIssue2: begin
        issue_valid     = 1'b1;
        dec_part2       = 1'b1;
        dec_instruction = op2_q;
        if (issue_ready) begin
          if (pc_load) begin
            pc_d = pc_load_value;
          end
          state_d = StFetch1;
        end
      end
      default: begin
        state_d = StFetch1;
      end
    endcase
  end

  // State registers with synchronous reset; reset drops any in-flight fetch or issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch1;
      pc_q    <= RESET_VECTOR;
      ir_q    <= '0;
      op2_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      op2_q   <= op2_d;
    end
  end

endmodule
